// File: rtl/cardinal_ring_stop.sv
// cardinal_ring_stop
// One stop of the unidirectional clockwise ring. There are two virtual
// channels (VC0/VC1), and each VC has four one-entry buffers: in_cw, in_pe,
// out_cw and out_pe. The polarity register alternates every cycle. While it
// equals p, VC p does its external handshakes and VC ~p routes internally.
//
// Ports
//   clk       in   clock, all state on the rising edge
//   reset     in   asynchronous active-low reset
//   polarity  out  current polarity, drives the NIC net_polarity
//   cwsi/cwri/cwdi  upstream ring link (send in, ready out, data in)
//   cwso/cwro/cwdo  downstream ring link (send out, ready in, data out)
//   pesi/pero/pedi  NIC injection link (request in, ready out, data in)
//   peso/peri/pedo  NIC ejection link (valid out, ready in, data out)
// Packet fields ([0:DATA_W-1] ordering): bit 0 VC, bit 1 direction,
// [HOP_MSB:HOP_LSB] hops remaining, [16:31] source, [32:63] payload.
module cardinal_ring_stop #(
    parameter int DATA_W  = 64,
    parameter int HOP_MSB = 8,
    parameter int HOP_LSB = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic              polarity,
    input  logic              cwsi,
    output logic              cwri,
    input  logic [0:DATA_W-1] cwdi,
    output logic              cwso,
    input  logic              cwro,
    output logic [0:DATA_W-1] cwdo,
    input  logic              pesi,
    output logic              pero,
    input  logic [0:DATA_W-1] pedi,
    output logic              peso,
    input  logic              peri,
    output logic [0:DATA_W-1] pedo
);

    localparam int HOP_W = HOP_LSB - HOP_MSB + 1;

    logic              r_p;
    logic [1:0]        r_inCwFull, r_inPeFull, r_outCwFull, r_outPeFull;
    logic [0:DATA_W-1] r_inCwData  [2];
    logic [0:DATA_W-1] r_inPeData  [2];
    logic [0:DATA_W-1] r_outCwData [2];
    logic [0:DATA_W-1] r_outPeData [2];
    // Round-robin pointer per VC and per target: 0 favours in_cw, 1 favours in_pe
    logic [1:0]        r_rrCw, r_rrPe;

    logic              w_q;
    logic              w_cwAccept, w_peAccept, w_cwSent, w_peSent;
    logic [HOP_W-1:0]  w_cwHop, w_peHop;
    logic              w_cwToRing, w_cwToEj, w_peToRing, w_peToEj;
    logic              w_ringClash, w_ringPickPe, w_ringGrant;
    logic              w_ejClash, w_ejPickPe, w_ejGrant;
    logic              w_cwMove, w_peMove;
    logic [0:DATA_W-1] w_ringData, w_ejData;

    assign w_q      = ~r_p;
    assign polarity = r_p;

    // External side: everything is indexed by the current polarity
    assign cwri = ~r_inCwFull[r_p];
    assign pero = ~r_inPeFull[r_p];
    assign cwso = r_outCwFull[r_p];
    assign cwdo = r_outCwData[r_p];
    assign peso = r_outPeFull[r_p];
    assign pedo = r_outPeData[r_p];

    assign w_cwAccept = cwsi & cwri;
    assign w_peAccept = pesi & pero;
    assign w_cwSent   = cwso & cwro;
    assign w_peSent   = peso & peri;

    // Internal routing on VC ~p. A source with zero hops heads for the local
    // ejection buffer. Any other source heads for the ring output. When the
    // two sources clash, the per-target pointer picks the winner. With no
    // clash, pickPe just names whichever source is requesting.
    always_comb begin
        w_cwHop      = r_inCwData[w_q][HOP_MSB:HOP_LSB];
        w_peHop      = r_inPeData[w_q][HOP_MSB:HOP_LSB];
        w_cwToEj     = r_inCwFull[w_q] && (w_cwHop == '0);
        w_cwToRing   = r_inCwFull[w_q] && (w_cwHop != '0);
        w_peToEj     = r_inPeFull[w_q] && (w_peHop == '0);
        w_peToRing   = r_inPeFull[w_q] && (w_peHop != '0);

        w_ringClash  = w_cwToRing & w_peToRing;
        w_ringPickPe = w_ringClash ? r_rrCw[w_q] : w_peToRing;
        w_ringGrant  = ~r_outCwFull[w_q] & (w_cwToRing | w_peToRing);

        w_ejClash    = w_cwToEj & w_peToEj;
        w_ejPickPe   = w_ejClash ? r_rrPe[w_q] : w_peToEj;
        w_ejGrant    = ~r_outPeFull[w_q] & (w_cwToEj | w_peToEj);

        w_cwMove     = (w_ringGrant & ~w_ringPickPe) | (w_ejGrant & ~w_ejPickPe);
        w_peMove     = (w_ringGrant & w_ringPickPe) | (w_ejGrant & w_ejPickPe);

        w_ringData   = w_ringPickPe ? r_inPeData[w_q] : r_inCwData[w_q];
        w_ringData[HOP_MSB:HOP_LSB] = (w_ringPickPe ? w_peHop : w_cwHop) - HOP_W'(1);
        w_ejData     = w_ejPickPe ? r_inPeData[w_q] : r_inCwData[w_q];
    end

    // VC p and VC ~p never touch the same buffer in one cycle. Because of
    // that, the fill and clear updates below never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p         <= 1'b0;
            r_inCwFull  <= '0;
            r_inPeFull  <= '0;
            r_outCwFull <= '0;
            r_outPeFull <= '0;
            r_rrCw      <= '0;
            r_rrPe      <= '0;
            for (int v = 0; v < 2; v++) begin
                r_inCwData[v]  <= '0;
                r_inPeData[v]  <= '0;
                r_outCwData[v] <= '0;
                r_outPeData[v] <= '0;
            end
        end else begin
            r_p <= ~r_p;

            if (w_cwAccept) begin
                r_inCwFull[r_p] <= 1'b1;
                r_inCwData[r_p] <= cwdi;
            end
            if (w_peAccept) begin
                r_inPeFull[r_p] <= 1'b1;
                r_inPeData[r_p] <= pedi;
            end
            if (w_cwSent) r_outCwFull[r_p] <= 1'b0;
            if (w_peSent) r_outPeFull[r_p] <= 1'b0;

            if (w_cwMove) r_inCwFull[w_q] <= 1'b0;
            if (w_peMove) r_inPeFull[w_q] <= 1'b0;
            if (w_ringGrant) begin
                r_outCwFull[w_q] <= 1'b1;
                r_outCwData[w_q] <= w_ringData;
            end
            if (w_ejGrant) begin
                r_outPeFull[w_q] <= 1'b1;
                r_outPeData[w_q] <= w_ejData;
            end
            // After a contested grant, the pointer moves to the loser
            if (w_ringGrant & w_ringClash) r_rrCw[w_q] <= ~w_ringPickPe;
            if (w_ejGrant & w_ejClash)     r_rrPe[w_q] <= ~w_ejPickPe;
        end
    end

endmodule

// File: tb/tb_cardinal_ring_stop.sv
// Directed bench for cardinal_ring_stop. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_cardinal_ring_stop;

    logic        clk = 1'b0;
    logic        reset;
    logic        polarity;
    logic        cwsi, cwri, cwso, cwro;
    logic        pesi, pero, peso, peri;
    logic [0:63] cwdi, cwdo, pedi, pedo;

    int compareCount = 0;
    int failCount    = 0;

    logic [0:63] pktA, pktB, pktC, pktD, pktX, pktY, pktL;

    cardinal_ring_stop dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .cwsi     (cwsi),
        .cwri     (cwri),
        .cwdi     (cwdi),
        .cwso     (cwso),
        .cwro     (cwro),
        .cwdo     (cwdo),
        .pesi     (pesi),
        .pero     (pero),
        .pedi     (pedi),
        .peso     (peso),
        .peri     (peri),
        .pedo     (pedo)
    );

    always #5 clk = ~clk;

    function automatic logic [0:63] mkPkt(input logic vc, input logic dir,
                                          input logic [7:0] hop,
                                          input logic [15:0] src,
                                          input logic [31:0] payload);
        logic [0:63] p;
        p        = '0;
        p[0]     = vc;
        p[1]     = dir;
        p[8:15]  = hop;
        p[16:31] = src;
        p[32:63] = payload;
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        compareCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic cwSend, input logic [0:63] cwData,
                                 input logic peSend, input logic [0:63] peData);
        cwsi = cwSend;
        cwdi = cwData;
        pesi = peSend;
        pedi = peData;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        cwro  = 1'b1;
        peri  = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0);
        #2;
        checkOutput("rst_polarity", 64'(polarity), 64'd0);
        checkOutput("rst_cwso", 64'(cwso), 64'd0);
        checkOutput("rst_peso", 64'(peso), 64'd0);
        checkOutput("rst_cwri", 64'(cwri), 64'd1);
        checkOutput("rst_pero", 64'(pero), 64'd1);
        checkOutput("rst_cwdo", cwdo, 64'd0);
        checkOutput("rst_pedo", pedo, 64'd0);
        stepCycle();

        // Inject and forward: PE injects VC0 hop=1 in the first polarity-0 cycle
        $display("[TB] inject and forward");
        reset = 1'b1;
        checkOutput("fwd_pol0", 64'(polarity), 64'd0);
        pktA = mkPkt(1'b0, 1'b1, 8'd1, 16'h1234, 32'hCAFE0001);
        applyStimulus(1'b0, '0, 1'b1, pktA);
        checkOutput("fwd_pero", 64'(pero), 64'd1);
        stepCycle();
        checkOutput("fwd_first_edge_pol", 64'(polarity), 64'd1);
        applyStimulus(1'b0, '0, 1'b0, '0);
        stepCycle();
        checkOutput("fwd_cwso", 64'(cwso), 64'd1);
        checkOutput("fwd_cwdo", cwdo, mkPkt(1'b0, 1'b1, 8'd0, 16'h1234, 32'hCAFE0001));
        stepCycle();
        stepCycle();
        checkOutput("fwd_cwso_drained", 64'(cwso), 64'd0);

        // Eject: VC1 hop=0 arrives from upstream
        $display("[TB] eject");
        stepCycle();
        pktB = mkPkt(1'b1, 1'b0, 8'd0, 16'h00AA, 32'h0BADF00D);
        applyStimulus(1'b1, pktB, 1'b0, '0);
        checkOutput("ej_cwri", 64'(cwri), 64'd1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("ej_peso_early", 64'(peso), 64'd0);
        stepCycle();
        checkOutput("ej_peso", 64'(peso), 64'd1);
        checkOutput("ej_pedo", pedo, pktB);
        checkOutput("ej_cwso", 64'(cwso), 64'd0);
        stepCycle();
        checkOutput("ej_peso_drained", 64'(peso), 64'd0);

        // Contention on VC1: in_cw hop=3 and in_pe hop=2 both target out_cw
        $display("[TB] contention");
        stepCycle();
        pktA = mkPkt(1'b1, 1'b0, 8'd3, 16'h0001, 32'h11111111);
        pktB = mkPkt(1'b1, 1'b1, 8'd2, 16'h0002, 32'h22222222);
        applyStimulus(1'b1, pktA, 1'b1, pktB);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0, '0);
        stepCycle();
        checkOutput("arb_first_cwso", 64'(cwso), 64'd1);
        checkOutput("arb_first_cwdo", cwdo, mkPkt(1'b1, 1'b0, 8'd2, 16'h0001, 32'h11111111));
        stepCycle();
        checkOutput("arb_gap_cwso", 64'(cwso), 64'd0);
        stepCycle();
        checkOutput("arb_second_cwso", 64'(cwso), 64'd1);
        checkOutput("arb_second_cwdo", cwdo, mkPkt(1'b1, 1'b1, 8'd1, 16'h0002, 32'h22222222));
        stepCycle();
        stepCycle();
        // Second clash: the pointer now favours the PE source
        pktC = mkPkt(1'b1, 1'b0, 8'd1, 16'h0003, 32'h33333333);
        pktD = mkPkt(1'b1, 1'b0, 8'd1, 16'h0004, 32'h44444444);
        applyStimulus(1'b1, pktC, 1'b1, pktD);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0, '0);
        stepCycle();
        checkOutput("arb_rr_pe_first", cwdo, mkPkt(1'b1, 1'b0, 8'd0, 16'h0004, 32'h44444444));
        stepCycle();
        stepCycle();
        checkOutput("arb_rr_cw_second", cwdo, mkPkt(1'b1, 1'b0, 8'd0, 16'h0003, 32'h33333333));
        stepCycle();

        // Backpressure on VC0
        $display("[TB] backpressure");
        checkOutput("bp_pol0", 64'(polarity), 64'd0);
        cwro = 1'b0;
        pktX = mkPkt(1'b0, 1'b0, 8'd2, 16'h00C0, 32'hAAAA0000);
        pktY = mkPkt(1'b0, 1'b0, 8'd2, 16'h00C1, 32'hBBBB0000);
        applyStimulus(1'b1, pktX, 1'b0, '0);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0, '0);
        stepCycle();
        checkOutput("bp_x_cwso", 64'(cwso), 64'd1);
        checkOutput("bp_x_cwdo", cwdo, mkPkt(1'b0, 1'b0, 8'd1, 16'h00C0, 32'hAAAA0000));
        applyStimulus(1'b1, pktY, 1'b0, '0);
        checkOutput("bp_y_cwri", 64'(cwri), 64'd1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0, '0);
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_hold_cwso", 64'(cwso), 64'd1);
            checkOutput("bp_hold_cwdo", cwdo, mkPkt(1'b0, 1'b0, 8'd1, 16'h00C0, 32'hAAAA0000));
            checkOutput("bp_hold_cwri", 64'(cwri), 64'd0);
            if (i < 2) begin
                stepCycle();
                stepCycle();
            end
        end
        cwro = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("bp_y_cwso", 64'(cwso), 64'd1);
        checkOutput("bp_y_cwdo", cwdo, mkPkt(1'b0, 1'b0, 8'd1, 16'h00C1, 32'hBBBB0000));
        checkOutput("bp_cwri_free", 64'(cwri), 64'd1);
        stepCycle();
        stepCycle();
        checkOutput("bp_drained", 64'(cwso), 64'd0);

        // Loopback: PE injects hop=0 on VC1
        $display("[TB] loopback");
        stepCycle();
        pktL = mkPkt(1'b1, 1'b1, 8'd0, 16'hBEEF, 32'h12345678);
        applyStimulus(1'b0, '0, 1'b1, pktL);
        checkOutput("lb_pero", 64'(pero), 64'd1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("lb_peso_early", 64'(peso), 64'd0);
        stepCycle();
        checkOutput("lb_peso", 64'(peso), 64'd1);
        checkOutput("lb_pedo", pedo, pktL);
        checkOutput("lb_cwso", 64'(cwso), 64'd0);
        stepCycle();

        // Reset mid-operation with traffic in every buffer
        $display("[TB] reset with traffic");
        cwro = 1'b0;
        peri = 1'b0;
        applyStimulus(1'b1, mkPkt(1'b0, 1'b0, 8'd1, 16'd1, 32'd1), 1'b1, mkPkt(1'b0, 1'b0, 8'd0, 16'd2, 32'd2));
        stepCycle();
        applyStimulus(1'b1, mkPkt(1'b1, 1'b0, 8'd1, 16'd3, 32'd3), 1'b1, mkPkt(1'b1, 1'b0, 8'd0, 16'd4, 32'd4));
        stepCycle();
        applyStimulus(1'b1, mkPkt(1'b0, 1'b0, 8'd5, 16'd5, 32'd5), 1'b1, mkPkt(1'b0, 1'b0, 8'd5, 16'd6, 32'd6));
        stepCycle();
        applyStimulus(1'b1, mkPkt(1'b1, 1'b0, 8'd5, 16'd7, 32'd7), 1'b1, mkPkt(1'b1, 1'b0, 8'd5, 16'd8, 32'd8));
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("full_cwso", 64'(cwso), 64'd1);
        checkOutput("full_peso", 64'(peso), 64'd1);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_polarity", 64'(polarity), 64'd0);
        checkOutput("mid_rst_cwso", 64'(cwso), 64'd0);
        checkOutput("mid_rst_peso", 64'(peso), 64'd0);
        checkOutput("mid_rst_cwri", 64'(cwri), 64'd1);
        checkOutput("mid_rst_pero", 64'(pero), 64'd1);
        checkOutput("mid_rst_cwdo", cwdo, 64'd0);
        checkOutput("mid_rst_pedo", pedo, 64'd0);
        stepCycle();
        stepCycle();
        cwro  = 1'b1;
        peri  = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            stepCycle();
            checkOutput("post_rst_cwso", 64'(cwso), 64'd0);
            checkOutput("post_rst_peso", 64'(peso), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/cardinal_ring_stop.md
# cardinal_ring_stop

One stop of the unidirectional clockwise ring. Each stop sits between a PE-side NIC and its two ring neighbours, and is the network-side counterpart of the NIC's `net_*` port. It has two virtual channels (even and odd), each with one-entry buffers. It generates the even/odd polarity the NIC uses, injects NIC packets, forwards through-traffic with hop decrement, and ejects packets whose hop count has reached zero.

## Interface
- `DATA_W`, 64: packet width. Bit fields below assume 64 and `[0:DATA_W-1]` ordering.
- `HOP_MSB`, 8 / `HOP_LSB`, 15: bounds of the 8-bit binary hop-remaining field.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `polarity`  out  1  current polarity; drives the local NIC `net_polarity`.
- `cwsi`  in  1  send from upstream stop.
- `cwri`  out  1  ready to upstream.
- `cwdi`  in  DATA_W  packet from upstream.
- `cwso`  out  1  send to downstream stop.
- `cwro`  in  1  ready from downstream.
- `cwdo`  out  DATA_W  packet to downstream.
- `pesi`  in  1  inject request from NIC (`net_so`).
- `pero`  out  1  inject ready to NIC (`net_ri`).
- `pedi`  in  DATA_W  injected packet (`net_do`).
- `peso`  out  1  eject valid to NIC (`net_si`).
- `peri`  in  1  eject ready from NIC (`net_ro`).
- `pedo`  out  DATA_W  ejected packet (`net_di`).

Packet fields:
- bit 0 is the VC.
- bit 1 is the direction; it passes through untouched.
- bits [8:15] hold hops remaining.
- bits [16:31] hold the source.
- bits [32:63] hold the payload.

## Operation
- **Buffers.** There are four one-entry buffers per VC v∈{0,1}: `in_cw[v]`, `in_pe[v]`, `out_cw[v]`, `out_pe[v]`. Each has a full flag and a data register.
- **Polarity.** The register `p` toggles on every edge while reset is deasserted. During a cycle with polarity `p`, VC `p` does external transfers and VC `~p` does internal routing.
- **External transfers (VC = p).**
  - `cwri = !in_cw[p].full`. On `cwsi && cwri`, `cwdi` is latched into `in_cw[p]`.
  - `pero = !in_pe[p].full`. On `pesi && pero`, `pedi` is latched into `in_pe[p]`.
  - `cwso = out_cw[p].full` and `cwdo = out_cw[p].data`. On `cwso && cwro`, `out_cw[p]` is cleared.
  - `peso = out_pe[p].full` and `pedo = out_pe[p].data`. On `peso && peri`, `out_pe[p]` is cleared.
  - The stop trusts senders to put packets only on VC = p. It does not check bit 0.
- **Internal routing (VC q = ~p).**
  - Sources are `in_cw[q]` and `in_pe[q]`.
  - A source with hop==0 targets `out_pe[q]` with the packet unchanged.
  - A source with hop>0 targets `out_cw[q]` with hop−1; all other bits are unchanged.
  - A move happens only if the target was empty at the start of the cycle. The move clears the source and fills the target at the edge.
  - Two sources may move in the same cycle if their targets differ.
- **Arbitration.** When both sources want the same target, a per-VC, per-target 1-bit round-robin pointer picks the winner.
  - After a grant, the pointer points at the loser.
  - The pointer changes only when there is contention.
  - The reset value favours `in_cw`.
- **Loopback.** A PE packet injected with hop==0 goes to `out_pe`, so it is ejected locally.
- **Hop range.** 8-bit hop, 0..255. The stop never decrements a zero hop, so there is no underflow.

## Timing
- **Reset values.** While `reset`=0, immediately:
  - `p`=0.
  - All full flags =0, all data registers =0, all arbitration pointers favour `in_cw`.
  - Outputs: `polarity`=0, `cwso`=`peso`=0, `cwri`=`pero`=1, `cwdo`=`pedo`=0.
- **Reset mid-operation.** Buffered packets are discarded. Nothing is emitted after release.
- **First edge after release.** `p` becomes 1.
- **Per-stop latency.** A packet accepted at edge E (VC v, p==v) moves internally at E+1 and is offered downstream in the cycle after E+1.
  - Transfer at E+2 is the minimum per-stop latency: 2 cycles.
  - Each stall on `cwro`/`peri` adds 2 cycles, because the next opportunity for that VC is the next same-polarity cycle.
- **Backpressure.** While stalled, `cwdo`/`pedo` are held stable.
- **Ready is registered.** `cwri` and `pero` depend only on register state, never combinationally on `cwsi`/`pesi`.
- **Same-edge accept and free.** An input buffer freed by an internal move at edge E is not visible as ready until its VC's next external cycle.
- **Full ring.** All buffers full with hop>0 stalls with no loss and no duplication.

## Test plan
1. **Reset.** Assert `reset`=0 with traffic in every buffer → `cwso`=`peso`=0, `cwri`=`pero`=1, `polarity`=0. After release, nothing is emitted until new injection.
2. **Inject and forward.** Release reset. In the first cycle with `polarity`=0, drive `pesi`=1 and a VC0 packet with hop=1 → `pero`=1 and the packet is accepted. In the next cycle with `polarity`=0 (2 cycles later), `cwso`=1 and `cwdo` equals the packet with hop=0.
3. **Eject.** On `cwsi` with a VC1 packet, hop=0, when `polarity`=1 → `peso`=1 and `pedo` equals the packet exactly 2 cycles later.
4. **Contention.** `in_cw[1]` hop=3 and `in_pe[1]` hop=2 are both present → the channel packet leaves first with hop=2. The PE packet leaves 2 cycles later with hop=1. The pointer now favours PE.
5. **Backpressure.** Hold `cwro`=0 for 6 cycles with `out_cw[0]` full → `cwso` stays asserted on every `polarity`=0 cycle with `cwdo` stable. Upstream sees `cwri`=0 once `in_cw[0]` also fills. Release gives in-order delivery with no loss.
6. **Loopback.** PE injects hop=0 on VC1 → the same packet appears on `pedo` with `peso`=1 2 cycles later. `cwso` stays 0.
